// File: rtl/wb_arbiter.sv
// wb_arbiter: merges pipeline writebacks and buffered long-latency results into one
// register-file write port, with a destination scoreboard for decode-stage hazard stalls.
module wb_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    input  logic        iss_valid,
    input  logic [4:0]  iss_addr,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        wen,
    output logic [4:0]  waddr,
    output logic [31:0] wdata,
    output logic [31:0] busy,
    output logic        sb_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [4:0]    addr_mem_q [DEPTH];
    logic [31:0]   data_mem_q [DEPTH];
    logic          wen_q, wen_d, err_q, err_d;
    logic [4:0]    waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d, busy_q, busy_d;
    logic          live_a, push, pop, head_wr;
    logic [4:0]    head_addr;
    logic [31:0]   head_data, set_mask, clr_mask;

    always_comb begin
        live_a    = a_valid && a_addr != 5'd0;
        push      = b_valid && count_q < FULL;
        pop       = !live_a && count_q != '0;
        head_addr = addr_mem_q[rp_q];
        head_data = data_mem_q[rp_q];
        head_wr   = pop && head_addr != 5'd0;
        count_d   = count_q + (AW+1)'(push) - (AW+1)'(pop);
        wp_d      = wp_q + AW'(push);
        rp_d      = rp_q + AW'(pop);
        wen_d     = live_a || head_wr;
        waddr_d   = live_a ? a_addr : head_wr ? head_addr : waddr_q;
        wdata_d   = live_a ? a_data : head_wr ? head_data : wdata_q;
        // OR-ing the set mask last lets a same-cycle reissue win over the clear
        set_mask  = (iss_valid && iss_addr != 5'd0) ? 32'(1) << iss_addr : '0;
        clr_mask  = head_wr ? 32'(1) << head_addr : '0;
        busy_d    = (busy_q & ~clr_mask) | set_mask;
        err_d     = err_q
                  | (iss_valid && iss_addr != 5'd0 && busy_q[iss_addr])
                  | (head_wr && !busy_q[head_addr])
                  | (live_a && busy_q[a_addr]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            busy_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[wp_q] <= b_addr;
            data_mem_q[wp_q] <= b_data;
        end
    end

    assign b_ready = count_q < FULL;
    assign wen     = wen_q;
    assign waddr   = waddr_q;
    assign wdata   = wdata_q;
    assign busy    = busy_q;
    assign sb_err  = err_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed vectors with hand-computed expectations for wb_arbiter (DEPTH=2).
module tb_wb_arbiter;
    logic        clk = 0;
    logic        rst = 1;
    logic        a_valid = 0, iss_valid = 0, b_valid = 0;
    logic [4:0]  a_addr = 0, iss_addr = 0, b_addr = 0;
    logic [31:0] a_data = 0, b_data = 0;
    logic        b_ready, wen, sb_err;
    logic [4:0]  waddr;
    logic [31:0] wdata, busy;
    int          n_cmp = 0, n_bad = 0;

    wb_arbiter #(.DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .wen(wen), .waddr(waddr), .wdata(wdata), .busy(busy), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_valid = 0; b_valid = 0; iss_valid = 0;
    endtask

    task automatic do_reset();
        idle(); rst = 1; step(); rst = 0;
    endtask

    initial begin
        do_reset();
        check("rst_wen", wen, 0);
        check("rst_waddr", waddr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_err", sb_err, 0);
        check("rst_bready", b_ready, 1);

        a_valid = 1; a_addr = 5; a_data = 32'hDEADBEEF; step();
        check("a_wen", wen, 1);
        check("a_waddr", waddr, 5);
        check("a_wdata", wdata, 32'hDEADBEEF);
        a_addr = 0; a_data = 32'h11111111; step();
        check("a0_wen", wen, 0);
        check("a0_hold_addr", waddr, 5);
        check("a0_hold_data", wdata, 32'hDEADBEEF);

        idle(); iss_valid = 1; iss_addr = 7; step();
        iss_valid = 0;
        check("iss7_busy", busy, 32'h80);
        b_valid = 1; b_addr = 7; b_data = 32'h12345678; step();
        b_valid = 0;
        check("b7_wen_early", wen, 0);
        check("b7_busy_held", busy, 32'h80);
        step();
        check("b7_wen", wen, 1);
        check("b7_waddr", waddr, 7);
        check("b7_wdata", wdata, 32'h12345678);
        check("b7_busy_clr", busy, 0);
        check("b7_err", sb_err, 0);

        iss_valid = 1; iss_addr = 10; step();
        iss_addr = 11; step();
        iss_valid = 0;
        check("iss_10_11", busy, 32'hC00);
        a_valid = 1; a_addr = 1; a_data = 32'hA1;
        b_valid = 1; b_addr = 10; b_data = 32'hA; step();
        check("fill1_bready", b_ready, 1);
        a_data = 32'hA2; b_addr = 11; b_data = 32'hB; step();
        b_valid = 0;
        check("fill2_bready", b_ready, 0);
        a_data = 32'hA3; step();
        check("full_bready", b_ready, 0);
        check("full_awaddr", waddr, 1);
        check("full_awdata", wdata, 32'hA3);
        a_valid = 0; step();
        check("drain1_waddr", waddr, 10);
        check("drain1_wdata", wdata, 32'hA);
        check("drain1_bready", b_ready, 1);
        check("drain1_busy", busy, 32'h800);
        step();
        check("drain2_wen", wen, 1);
        check("drain2_waddr", waddr, 11);
        check("drain2_wdata", wdata, 32'hB);
        check("drain2_busy", busy, 0);
        check("drain_err", sb_err, 0);

        iss_valid = 1; iss_addr = 9; step();
        iss_valid = 0;
        b_valid = 1; b_addr = 9; b_data = 32'h99; step();
        b_valid = 0;
        a_valid = 1; a_addr = 3; a_data = 32'h33; step();
        check("prio_waddr", waddr, 3);
        check("prio_wdata", wdata, 32'h33);
        check("prio_busy9", busy, 32'h200);
        a_valid = 0; b_valid = 1; b_addr = 0; b_data = 32'h55; step();
        check("head9_waddr", waddr, 9);
        check("head9_wdata", wdata, 32'h99);
        check("head9_busy", busy, 0);
        a_valid = 1; a_addr = 2; a_data = 32'h22; b_data = 32'h56; step();
        b_valid = 0;
        check("cnt1_then_full", b_ready, 0);
        check("cnt1_a_waddr", waddr, 2);
        a_valid = 0; step();
        check("x0_pop_wen", wen, 0);
        check("x0_pop_hold", waddr, 2);
        check("x0_pop_bready", b_ready, 1);
        step();
        check("x0_pop2_wen", wen, 0);
        check("seq_err", sb_err, 0);

        iss_valid = 1; iss_addr = 4; step(); step();
        iss_valid = 0;
        check("reiss_err", sb_err, 1);
        step();
        check("err_sticky", sb_err, 1);
        do_reset();
        check("err_rst", sb_err, 0);
        check("err_rst_busy", busy, 0);

        b_valid = 1; b_addr = 6; b_data = 32'h66; step();
        b_valid = 0; step();
        check("nobusy_wen", wen, 1);
        check("nobusy_waddr", waddr, 6);
        check("nobusy_err", sb_err, 1);
        do_reset();

        iss_valid = 1; iss_addr = 8; step();
        iss_valid = 0; a_valid = 1; a_addr = 8; a_data = 32'h88; step();
        a_valid = 0;
        check("waw_err", sb_err, 1);
        check("waw_wen", wen, 1);
        check("waw_wdata", wdata, 32'h88);
        do_reset();

        iss_valid = 1; iss_addr = 12; step();
        iss_addr = 13; a_valid = 1; a_addr = 1; a_data = 32'h1;
        b_valid = 1; b_addr = 12; b_data = 32'hC; step();
        iss_valid = 0; b_addr = 13; b_data = 32'hD; step();
        check("pre_rst_bready", b_ready, 0);
        check("pre_rst_busy", busy, 32'h3000);
        idle(); rst = 1; step(); rst = 0;
        check("mid_rst_bready", b_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_wen", wen, 0);
        check("mid_rst_waddr", waddr, 0);
        step();
        check("no_stale1", wen, 0);
        step();
        check("no_stale2", wen, 0);
        check("no_stale_err", sb_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Register-file write-side controller for the pipelined core: merges single-cycle pipeline writebacks with results returned by long-latency units (multiplier/divider, load-miss return) into the one write port of the register file. Long-latency results are buffered in a small FIFO and drained into idle write slots. A 32-bit scoreboard marks destination registers with outstanding long-latency results so the decode stage can stall on RAW/WAW hazards.

## Interface

Parameters:
- DEPTH, 2, long-latency result FIFO entries (power of two, 2..8)

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- a_valid  input  1  pipeline writeback valid this cycle (no back-pressure)
- a_addr  input  5  pipeline destination register
- a_data  input  32  pipeline result
- iss_valid  input  1  a long-latency op is issued this cycle
- iss_addr  input  5  its destination register
- b_valid  input  1  long-latency result offered
- b_ready  output  1  FIFO can accept a result
- b_addr  input  5  long-latency destination register
- b_data  input  32  long-latency result
- wen  output  1  register-file write enable
- waddr  output  5  register-file write address
- wdata  output  32  register-file write data
- busy  output  32  scoreboard; bit n = result for xn outstanding
- sb_err  output  1  sticky protocol-error flag

## Operation

- Port A: a_valid with a_addr != 0 is a "live A write". a_valid with a_addr == 0 is discarded and leaves the slot free.
- Port B push: when b_valid && b_ready, {b_addr, b_data} is pushed. b_addr == 0 results are pushed and consume a slot, but the write is suppressed at drain.
- b_ready = (count < DEPTH), from registered count only. There is no pop-through when full.
- Drain: in any cycle with no live A write and count > 0, the FIFO head is popped.
- Output stage is registered. In the next cycle:
  - a live A write drives wen=1 with A's addr/data;
  - otherwise a popped head with nonzero addr drives wen=1 with the head's addr/data;
  - otherwise wen=0, and waddr/wdata hold their previous values.
- Priority: a live A write always beats the FIFO head. The head waits with no starvation guard, because the pipeline cannot sustain writes every cycle indefinitely.
- Scoreboard set: iss_valid && iss_addr != 0 sets busy[iss_addr] on the next edge.
- Scoreboard clear: a popped head with nonzero addr clears busy[head addr] on the same edge that registers wen.
- Set and clear of the same bit in the same cycle: set wins.
- sb_err is sticky until rst. It sets on any of:
  - iss_valid to an already-busy nonzero register;
  - a pop of a nonzero addr whose busy bit is clear;
  - a live A write whose a_addr bit is busy. This is a WAW violation; the A write is still performed.
- FIFO pointers are log2(DEPTH) bits wide and wrap naturally. count is log2(DEPTH)+1 bits.

## Timing

- Reset (rst high at an edge): FIFO emptied (count=0), b_ready=1, wen=0, waddr=0, wdata=0, busy=0, sb_err=0. A reset mid-operation discards buffered results and all scoreboard state.
- Latency, A: 1 cycle. a_valid in cycle t gives wen in t+1.
- Latency, B: minimum 2 cycles. Push in t, pop in t+1 (if no live A write), wen in t+2. Every cycle blocked by a live A write adds 1.
- Throughput: one register write per cycle. Push and pop in the same cycle leave count unchanged.
- b_ready deasserts in the cycle after the push that makes count == DEPTH. It reasserts the cycle after the next pop.
- busy bit visibility:
  - rises the cycle after issue;
  - falls in the same cycle wen presents the write.
  - The decode stage therefore sees busy low exactly when the value is in the register file.

## Test plan

- Reset, then a_valid=1, a_addr=5, a_data=0xDEADBEEF -> next cycle wen=1, waddr=5, wdata=0xDEADBEEF. Then a_addr=0 -> wen=0.
- iss x7, then b push {7, 0x12345678} with A idle -> busy[7]=1 the cycle after issue; wen=1, waddr=7 two cycles after push, with busy[7]=0 in that same cycle; sb_err=0.
- DEPTH=2: push two B results while live A writes every cycle -> b_ready=0 after the 2nd push. Stop A -> writes drain in FIFO order, b_ready returns to 1 after the first pop.
- Same-cycle live A write (x3) and non-empty FIFO (head x9) -> x3 written first, x9 the following cycle. Also push while popping at count=1 -> count stays 1.
- Error cases, each followed by rst:
  - iss x4 twice without a result -> sb_err=1;
  - B pop of x6 with busy[6]=0 -> sb_err=1;
  - rst -> sb_err=0, busy=0.
- Two entries buffered and busy bits set; assert rst -> next cycle count=0, b_ready=1, busy=0, wen=0, and no stale write ever appears.
